deint_frame_arbiter: RTL and testbench

//  Frame-granular round-robin arbiter that shares one de_interleaver between NUM_REQ AXIS

---
 rtl/deint_frame_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_deint_frame_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deint_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of a shared de_interleaver.
// Whole frames from one source are forwarded at a time; the granted source ID is queued
// so that the de-interleaved output can be tagged with tdest and tlast.
// Optional feature macro: DEINT_ARB_STATS_EN adds per-source completed-frame counters
// on the stat_frames port.
module deint_frame_arbiter #(
  parameter int CODEWORD_SIZE_IN_32 = 65,
  parameter int NUM_CODEWORDS       = 4,
  parameter int NUM_REQ             = 2,
  parameter int ID_FIFO_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [32*NUM_REQ-1:0]      s_axis_tdata,
  input  logic [NUM_REQ-1:0]         s_axis_tvalid,
  output logic [NUM_REQ-1:0]         s_axis_tready,
  output logic [31:0]                d_axis_tdata,
  output logic                       d_axis_tvalid,
  input  logic                       d_axis_tready,
  input  logic [31:0]                r_axis_tdata,
  input  logic                       r_axis_tvalid,
  output logic                       r_axis_tready,
  output logic [31:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(NUM_REQ)-1:0] m_axis_tdest,
`ifdef DEINT_ARB_STATS_EN
  output logic [16*NUM_REQ-1:0]      stat_frames,
`endif
  output logic                       err_orphan
);

  localparam int FRAME_WORDS = CODEWORD_SIZE_IN_32 * NUM_CODEWORDS;
  localparam int CW          = $clog2(FRAME_WORDS);
  localparam int IW          = $clog2(NUM_REQ);
  localparam int AW          = $clog2(ID_FIFO_DEPTH);

  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_WORDS - 1);
  localparam logic [0:0]    IDLE      = 1'b0;
  localparam logic [0:0]    BUSY      = 1'b1;

  logic [0:0]            state;
  logic [IW-1:0]         grant;
  logic [IW-1:0]         rr_ptr;
  logic [CW-1:0]         in_cnt;
  logic [CW-1:0]         out_cnt;
  logic [IW-1:0]         fifo_mem [ID_FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           fifo_cnt;

  logic [2*NUM_REQ-1:0]  req_rot;
  logic                  pick_valid;
  int                    pick_sum;
  logic [IW-1:0]         pick_id;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  in_beat;
  logic                  out_beat;
  logic                  frame_done;

  assign fifo_full  = (fifo_cnt == (AW+1)'(ID_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  // Round-robin pick: rotate requests so bit 0 is rr_ptr, take the first set bit
  always_comb begin
    req_rot    = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr;
    pick_valid = 1'b0;
    pick_sum   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && req_rot[i]) begin
        pick_valid = 1'b1;
        pick_sum   = int'(rr_ptr) + i;
      end
    end
    pick_id = IW'((pick_sum >= NUM_REQ) ? pick_sum - NUM_REQ : pick_sum);
  end

  // Input mux toward the de_interleaver, open only to the granted source while BUSY
  always_comb begin
    d_axis_tdata  = '0;
    d_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == IW'(k)) begin
        d_axis_tdata = s_axis_tdata[32*k +: 32];
        if (state == BUSY) begin
          d_axis_tvalid    = s_axis_tvalid[k];
          s_axis_tready[k] = d_axis_tready;
        end
      end
    end
  end

  assign push       = (state == IDLE) && pick_valid && !fifo_full;
  assign in_beat    = d_axis_tvalid && d_axis_tready;
  assign frame_done = in_beat && (in_cnt == LAST_BEAT);

  // Output side is a pass-through; tagging comes from out_cnt and the ID FIFO head
  assign m_axis_tdata  = r_axis_tdata;
  assign m_axis_tvalid = r_axis_tvalid;
  assign r_axis_tready = m_axis_tready;
  assign m_axis_tlast  = (out_cnt == LAST_BEAT);
  assign m_axis_tdest  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign out_beat      = r_axis_tvalid && m_axis_tready;
  assign pop           = out_beat && m_axis_tlast && !fifo_empty;

  // Grant FSM and input word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      in_cnt <= '0;
    end else if (state == IDLE) begin
      if (push) begin
        state  <= BUSY;
        grant  <= pick_id;
        rr_ptr <= (pick_id == IW'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
        in_cnt <= '0;
      end
    end else if (in_beat) begin
      if (in_cnt == LAST_BEAT) begin
        in_cnt <= '0;
        state  <= IDLE;
      end else begin
        in_cnt <= in_cnt + 1'b1;
      end
    end
  end

  // Output word counter and sticky orphan flag; the counter runs even without an owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt    <= '0;
      err_orphan <= 1'b0;
    end else if (out_beat) begin
      out_cnt <= (out_cnt == LAST_BEAT) ? '0 : out_cnt + 1'b1;
      if (fifo_empty) err_orphan <= 1'b1;
    end
  end

  // In-order ID FIFO of frames in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < ID_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= pick_id;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

`ifdef DEINT_ARB_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  // Per-source completed input frame counters, free-running 16-bit wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REQ; k++) stat_cnt[k] <= '0;
    end else if (frame_done) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant == IW'(k)) stat_cnt[k] <= stat_cnt[k] + 16'd1;
      end
    end
  end

  // Flatten counters onto the stats port
  always_comb begin
    stat_frames = '0;
    for (int k = 0; k < NUM_REQ; k++) stat_frames[16*k +: 16] = stat_cnt[k];
  end
`endif

endmodule

// File: tb/tb_deint_frame_arbiter.sv
// Randomized bench for deint_frame_arbiter. The de_interleaver is stood in for by a
// loopback queue (d beats come back out on r in order). Source words carry
// {source id, running word index} so every output beat can be checked for owner and
// position within its frame.
module tb_deint_frame_arbiter;
  localparam int CWS   = 65;
  localparam int NCW   = 4;
  localparam int NR    = 2;
  localparam int DEPTH = 4;
  localparam int FW    = CWS * NCW;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*NR-1:0] s_tdata;
  logic [NR-1:0]   s_tvalid;
  logic [NR-1:0]   s_tready;
  logic [31:0]     d_tdata;
  logic            d_tvalid;
  logic            d_ready;
  logic [31:0]     r_tdata;
  logic            r_valid;
  logic            r_tready;
  logic [31:0]     m_tdata;
  logic            m_tvalid;
  logic            m_ready;
  logic            m_tlast;
  logic [0:0]      m_tdest;
  logic            err;
`ifdef DEINT_ARB_STATS_EN
  logic [16*NR-1:0] stat_frames;
`endif

  deint_frame_arbiter #(
    .CODEWORD_SIZE_IN_32(CWS),
    .NUM_CODEWORDS      (NCW),
    .NUM_REQ            (NR),
    .ID_FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .d_axis_tdata (d_tdata),
    .d_axis_tvalid(d_tvalid),
    .d_axis_tready(d_ready),
    .r_axis_tdata (r_tdata),
    .r_axis_tvalid(r_valid),
    .r_axis_tready(r_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_ready),
    .m_axis_tlast (m_tlast),
    .m_axis_tdest (m_tdest),
`ifdef DEINT_ARB_STATS_EN
    .stat_frames  (stat_frames),
`endif
    .err_orphan   (err)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Stimulus controls
  bit [NR-1:0] src_en;
  int          vprob, dprob, mprob, rprob;
  bit          orphan_mode;
  int          seq [NR];
  bit [NR-1:0] s_fire;
  bit          r_fire;
  logic [31:0] lq [$];

  // Behavioural model: owner of the input port (-1 none), queue of frames in flight
  int   owner, in_n, rr, out_n;
  bit   orphan;
  int   idq [$];
  int   grant_log [$];
  int   tdest_log [$];
  int   m_beats, last_tlast_at;
  logic [31:0] last_tlast_data;
  int   frames [NR];
  logic [NR-1:0] exp_sready;
  bit   exp_dvalid, full, found;
  int   g;

  // Per-cycle compare against the model, then advance the model by one clock
  always @(negedge clk) begin
    if (rst) begin
      owner = -1; in_n = 0; rr = 0; out_n = 0; orphan = 0;
      idq.delete(); grant_log.delete(); tdest_log.delete();
      m_beats = 0; last_tlast_at = 0; last_tlast_data = '0;
      for (int k = 0; k < NR; k++) frames[k] = 0;
      s_fire = '0; r_fire = 0;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_d_tvalid", d_tvalid, 0);
      chk("rst_err", err, 0);
      chk("rst_tlast", m_tlast, 0);
    end else begin
      exp_sready = '0;
      if (owner >= 0 && d_ready) exp_sready[owner] = 1'b1;
      exp_dvalid = (owner >= 0) && s_tvalid[owner];
      chk("s_tready", s_tready, exp_sready);
      chk("d_tvalid", d_tvalid, exp_dvalid);
      if (exp_dvalid) chk("d_tdata", d_tdata, s_tdata[32*owner +: 32]);
      chk("m_tvalid", m_tvalid, r_valid);
      chk("m_tdata", m_tdata, r_tdata);
      chk("r_tready", r_tready, m_ready);
      chk("m_tlast", m_tlast, out_n == FW - 1);
      chk("m_tdest", m_tdest, (idq.size() > 0) ? idq[0] : 0);
      chk("err_orphan", err, orphan);
`ifdef DEINT_ARB_STATS_EN
      for (int k = 0; k < NR; k++) chk("stat", stat_frames[16*k +: 16], frames[k] % 65536);
`endif
      s_fire = s_tvalid & s_tready;
      r_fire = r_valid && r_tready;

      full = idq.size() >= DEPTH;
      if (r_valid && m_ready) begin
        m_beats++;
        if (idq.size() == 0) orphan = 1;
        else begin
          chk("m_src", m_tdata[31:24], idq[0]);
          chk("m_pos", int'(m_tdata[23:0]) % FW, out_n);
        end
        if (out_n == FW - 1) begin
          tdest_log.push_back((idq.size() > 0) ? idq[0] : 0);
          last_tlast_at   = m_beats;
          last_tlast_data = m_tdata;
          out_n = 0;
          if (idq.size() > 0) void'(idq.pop_front());
        end else out_n++;
      end

      if (owner < 0) begin
        found = 0;
        if (!full) begin
          for (int i = 0; i < NR; i++) begin
            if (!found && s_tvalid[(rr + i) % NR]) begin
              found = 1;
              g = (rr + i) % NR;
            end
          end
        end
        if (found) begin
          idq.push_back(g);
          grant_log.push_back(g);
          owner = g;
          rr = (g + 1) % NR;
          in_n = 0;
        end
      end else if (s_tvalid[owner] && d_ready) begin
        lq.push_back(s_tdata[32*owner +: 32]);
        in_n++;
        if (in_n == FW) begin
          frames[owner]++;
          owner = -1;
        end
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (s_fire[k]) seq[k]++;
      if (r_fire && !orphan_mode && lq.size() > 0) void'(lq.pop_front());
      for (int k = 0; k < NR; k++) begin
        s_tvalid[k] = src_en[k] && ($urandom_range(0, 99) < vprob);
        s_tdata[32*k +: 32] = {8'(k), 24'(seq[k])};
      end
      d_ready = $urandom_range(0, 99) < dprob;
      m_ready = $urandom_range(0, 99) < mprob;
      if (orphan_mode) begin
        r_valid = 1'($urandom_range(0, 1));
        r_tdata = $urandom;
      end else begin
        r_valid = (lq.size() > 0) && ($urandom_range(0, 99) < rprob);
        r_tdata = (lq.size() > 0) ? lq[0] : 32'd0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    src_en = '0; orphan_mode = 0;
    s_tvalid = '0; r_valid = 1'b0; s_tdata = '0; r_tdata = '0;
    for (int k = 0; k < NR; k++) seq[k] = 0;
    lq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vprob = 100; dprob = 100; mprob = 100; rprob = 100;
  endtask

  int exp_g [4] = '{0, 1, 0, 1};

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tvalid = '0; d_ready = 1'b0; r_tdata = '0; r_valid = 1'b0; m_ready = 1'b0;
    src_en = '0; orphan_mode = 0;
    vprob = 100; dprob = 100; mprob = 100; rprob = 100;
    for (int k = 0; k < NR; k++) seq[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single source, full throughput
    do_reset();
    src_en = 2'b01;
    for (int i = 0; i < 2000 && tdest_log.size() == 0; i++) cycles(1);
    chk("t1_tlast_seen", tdest_log.size(), 1);
    chk("t1_tlast_at", last_tlast_at, FW);
    chk("t1_tlast_data", last_tlast_data, {8'd0, 24'(FW - 1)});
    if (tdest_log.size() > 0) chk("t1_tdest", tdest_log[0], 0);

    // 2: both sources continuously valid alternate frame by frame
    do_reset();
    src_en = 2'b11;
    for (int i = 0; i < 4000 && (grant_log.size() < 4 || tdest_log.size() < 2); i++) cycles(1);
    chk("t2_grants", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t2_grant_order", grant_log[i], exp_g[i]);
    if (tdest_log.size() >= 2) chk("t2_tdest_second", tdest_log[1], 1);

    // 3: input handshake stalls mid-frame
    do_reset();
    src_en = 2'b01;
    dprob = 50;
    for (int i = 0; i < 3000 && tdest_log.size() == 0; i++) cycles(1);
    chk("t3_tlast_at", last_tlast_at, FW);
    chk("t3_frames", frames[0], 1);

    // 4: ID FIFO full withholds a 5th grant until a pop
    do_reset();
    src_en = 2'b11;
    mprob = 0;
    for (int i = 0; i < 3000 && !(grant_log.size() == 4 && owner < 0); i++) cycles(1);
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      chk("t4_withheld", s_tready, 0);
    end
    chk("t4_grants_held", grant_log.size(), 4);
    mprob = 100;
    for (int i = 0; i < 600 && grant_log.size() < 5; i++) cycles(1);
    chk("t4_grant_after_pop", grant_log.size(), 5);

    // 5: orphan beats set the sticky error; reset clears everything
    do_reset();
    orphan_mode = 1;
    cycles(10);
    orphan_mode = 0;
    cycles(1);
    chk("t5_err_set", err, 1);
    cycles(20);
    chk("t5_err_sticky", err, 1);
    do_reset();
    chk("t5_err_cleared", err, 0);
    src_en = 2'b01;
    cycles(100);
    chk("t5_midframe_ready", s_tready, 2'b01);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_s_tready", s_tready, 0);
    chk("t5_rst_d_tvalid", d_tvalid, 0);
    chk("t5_rst_tlast", m_tlast, 0);
    do_reset();

    // Random traffic on both sources with back-pressure everywhere
    src_en = 2'b11;
    vprob = 70; dprob = 70; mprob = 70; rprob = 80;
    cycles(4000);
    chk("rand_progress", (frames[0] > 0) && (frames[1] > 0), 1);

`ifdef DEINT_ARB_STATS_EN
    // 6: frame statistics
    do_reset();
    src_en = 2'b10;
    for (int i = 0; i < 2000 && frames[1] < 3; i++) cycles(1);
    chk("t6_stat_src1", stat_frames[31:16], 3);
    chk("t6_stat_src0", stat_frames[15:0], 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
